// File: rtl/mem_lsu_pkg.sv
// Shared CPU definitions for the MEM-stage load/store unit and the data memory.
package mem_lsu_pkg;

    localparam int unsigned CPU_ADDR_W    = 16;
    localparam int unsigned CPU_DATA_W    = 16;
    localparam int unsigned CPU_MEM_DEPTH = 128;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_WRITE,
        LSU_READ,
        LSU_RESP
    } lsu_state_t;

endpackage

// File: rtl/mem_lsu_if.sv
// Pipeline request/response handshake and data-memory port of the LSU.
interface mem_lsu_if
    import mem_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = CPU_ADDR_W,
    parameter int unsigned DATA_W = CPU_DATA_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              mem_write_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_read_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_write_en, mem_addr, mem_write_data
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_read_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_write_en, mem_addr, mem_write_data
    );

endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store initiator: one request at a time, sole master of the
// data-memory port, one response per request, out-of-range requests rejected.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W    = CPU_ADDR_W,
    parameter int unsigned DATA_W    = CPU_DATA_W,
    parameter int unsigned MEM_DEPTH = CPU_MEM_DEPTH,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic       clk,
    input  logic       reset,
    mem_lsu_if.master  bus,
    output logic [7:0] err_count,
    output logic       busy
);

    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    lsu_state_t        state, state_nxt;
    logic              ready_q;
    logic              accept;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  lat_cnt;

    // Upper bits above the memory depth must be zero; no aliasing.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(MEM_DEPTH);
    endfunction

    assign accept = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LSU_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        bus.req_ready      = 1'b0;
        bus.rsp_valid      = 1'b0;
        bus.mem_write_en   = 1'b0;
        busy               = 1'b1;
        case (state)
            LSU_IDLE: begin
                busy          = 1'b0;
                bus.req_ready = ready_q;
                if (accept) begin
                    if (!in_range(bus.req_addr)) state_nxt = LSU_RESP;
                    else if (bus.req_we)         state_nxt = LSU_WRITE;
                    else                         state_nxt = LSU_READ;
                end
            end
            LSU_WRITE: begin
                bus.mem_write_en = 1'b1;
                state_nxt        = LSU_RESP;
            end
            LSU_READ: begin
                if (lat_cnt == '0) state_nxt = LSU_RESP;
            end
            LSU_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = LSU_IDLE;
            end
            default: state_nxt = LSU_IDLE;
        endcase
    end

    assign bus.mem_addr       = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.rsp_rdata      = rdata_q;
    assign bus.rsp_err        = err_q;

    // ready_q keeps req_ready low until the first edge after reset releases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            lat_cnt   <= '0;
            err_count <= '0;
        end else begin
            ready_q <= 1'b1;
            case (state)
                LSU_IDLE: begin
                    if (accept) begin
                        if (in_range(bus.req_addr)) begin
                            addr_q  <= bus.req_addr;
                            wdata_q <= bus.req_wdata;
                            lat_cnt <= CNT_W'(RD_LAT - 1);
                        end else begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            if (err_count != '1) err_count <= err_count + 8'd1;
                        end
                    end
                end
                LSU_WRITE: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                LSU_READ: begin
                    if (lat_cnt == '0) begin
                        rdata_q <= bus.mem_read_data;
                        err_q   <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a RD_LAT=1 unit for most checks and a RD_LAT=3
// unit for the latency check, both reading one negedge-write memory.
module tb_mem_lsu;

    logic clk;
    logic reset;
    logic [7:0] err_count1, err_count3;
    logic       busy1, busy3;

    logic [15:0] mem [128];
    int          we_cnt = 0;
    int          n_cmp  = 0;
    int          n_bad  = 0;

    mem_lsu_if #(.ADDR_W(16), .DATA_W(16)) b1 ();
    mem_lsu_if #(.ADDR_W(16), .DATA_W(16)) b3 ();

    mem_lsu #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(128), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .bus(b1), .err_count(err_count1), .busy(busy1)
    );

    mem_lsu #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(128), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .bus(b3), .err_count(err_count3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb b1.mem_read_data = (b1.mem_addr < 16'd128) ? mem[b1.mem_addr[6:0]] : 16'h0;
    always_comb b3.mem_read_data = (b3.mem_addr < 16'd128) ? mem[b3.mem_addr[6:0]] : 16'h0;

    always @(negedge clk) begin
        if (b1.mem_write_en) begin
            if (b1.mem_addr < 16'd128) mem[b1.mem_addr[6:0]] <= b1.mem_write_data;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        b1.req_valid = 1'b1;
        b1.req_we    = we;
        b1.req_addr  = addr;
        b1.req_wdata = wdata;
    endtask

    // Returns #1 after the edge that accepted the pending request.
    task automatic wait_accept(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (b1.req_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        b1.req_valid = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          output logic [15:0] rdata, output logic err, output int lat);
        logic ok;
        start_req(we, addr, wdata);
        wait_accept(ok);
        check("req_accepted", ok, 1);
        lat = 1;
        while (!b1.rsp_valid && lat < 50) begin
            tick();
            lat++;
        end
        rdata = b1.rsp_rdata;
        err   = b1.rsp_err;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rd;
        logic        er;
        int          lat;
        logic        ok;

        for (int i = 0; i < 128; i++) mem[i] = 16'h0;
        mem[127] = 16'h7777;
        mem[3]   = 16'h1234;
        mem[10]  = 16'h00A5;

        b1.req_valid = 0; b1.req_we = 0; b1.req_addr = '0; b1.req_wdata = '0; b1.rsp_ready = 1;
        b3.req_valid = 0; b3.req_we = 0; b3.req_addr = '0; b3.req_wdata = '0; b3.rsp_ready = 1;
        reset = 1'b0;
        #1 reset = 1'b1;
        #12;
        check("rst_req_ready", b1.req_ready, 0);
        check("rst_rsp_valid", b1.rsp_valid, 0);
        check("rst_rsp_rdata", b1.rsp_rdata, 0);
        check("rst_rsp_err", b1.rsp_err, 0);
        check("rst_mem_we", b1.mem_write_en, 0);
        check("rst_mem_addr", b1.mem_addr, 0);
        check("rst_mem_wdata", b1.mem_write_data, 0);
        check("rst_err_count", err_count1, 0);
        check("rst_busy", busy1, 0);
        reset = 1'b0;
        #1 check("rel_ready_low", b1.req_ready, 0);
        tick();
        check("rel_ready_high", b1.req_ready, 1);

        // store 0xBEEF to 5, cycle by cycle
        start_req(1'b1, 16'h0005, 16'hBEEF);
        wait_accept(ok);
        check("st_accepted", ok, 1);
        check("st_we", b1.mem_write_en, 1);
        check("st_addr", b1.mem_addr, 16'h0005);
        check("st_wdata", b1.mem_write_data, 16'hBEEF);
        check("st_busy", busy1, 1);
        check("st_ready_low", b1.req_ready, 0);
        check("st_no_rsp", b1.rsp_valid, 0);
        tick();
        check("st_we_off", b1.mem_write_en, 0);
        check("st_rsp_valid", b1.rsp_valid, 1);
        check("st_rsp_err", b1.rsp_err, 0);
        check("st_rsp_rdata", b1.rsp_rdata, 0);
        tick();
        check("st_idle_valid", b1.rsp_valid, 0);
        check("st_idle_ready", b1.req_ready, 1);
        check("st_we_cycles", we_cnt, 1);
        check("st_mem5", mem[5], 16'hBEEF);

        do_req(1'b0, 16'h0005, 16'h0, rd, er, lat);
        check("ld5_rdata", rd, 16'hBEEF);
        check("ld5_err", er, 0);
        check("ld5_lat", lat, 2);

        // range edges
        do_req(1'b0, 16'h007F, 16'h0, rd, er, lat);
        check("ld7f_rdata", rd, 16'h7777);
        check("ld7f_err", er, 0);
        check("ld7f_lat", lat, 2);
        do_req(1'b0, 16'h0080, 16'h0, rd, er, lat);
        check("ld80_err", er, 1);
        check("ld80_rdata", rd, 0);
        check("ld80_lat", lat, 1);
        do_req(1'b1, 16'hFFFF, 16'hAAAA, rd, er, lat);
        check("stffff_err", er, 1);
        check("stffff_rdata", rd, 0);
        check("range_we_cycles", we_cnt, 1);
        check("range_err_count", err_count1, 2);
        do_req(1'b0, 16'h0105, 16'h0, rd, er, lat);
        check("ld105_err", er, 1);
        check("ld105_rdata", rd, 0);
        check("alias_err_count", err_count1, 3);

        // response backpressure with a competing request held on req_valid
        b1.rsp_ready = 1'b0;
        start_req(1'b0, 16'h0003, 16'h0);
        wait_accept(ok);
        check("bp_accepted", ok, 1);
        tick();
        start_req(1'b1, 16'h0006, 16'h5555);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", b1.rsp_valid, 1);
            check("bp_rdata", b1.rsp_rdata, 16'h1234);
            check("bp_ready_low", b1.req_ready, 0);
            tick();
        end
        b1.rsp_ready = 1'b1;
        tick();
        check("bp_done_valid", b1.rsp_valid, 0);
        check("bp_done_ready", b1.req_ready, 1);
        check("bp_no_early_write", we_cnt, 1);
        wait_accept(ok);
        check("bp_next_accepted", ok, 1);
        check("bp_next_we", b1.mem_write_en, 1);
        check("bp_next_addr", b1.mem_addr, 16'h0006);
        tick();
        tick();
        check("bp_single_write", we_cnt, 2);
        check("bp_mem6", mem[6], 16'h5555);

        // RD_LAT = 3 unit
        b3.req_valid = 1'b1; b3.req_we = 1'b0; b3.req_addr = 16'd10;
        check("lat3_ready", b3.req_ready, 1);
        tick();
        b3.req_valid = 1'b0;
        lat = 1;
        while (!b3.rsp_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("lat3_lat", lat, 4);
        check("lat3_rdata", b3.rsp_rdata, 16'h00A5);
        check("lat3_err", b3.rsp_err, 0);
        tick();

        // async reset while in WRITE
        start_req(1'b1, 16'h0007, 16'h9999);
        wait_accept(ok);
        check("rw_we_before", b1.mem_write_en, 1);
        #2 reset = 1'b1;
        #1;
        check("rw_we", b1.mem_write_en, 0);
        check("rw_busy", busy1, 0);
        check("rw_rsp_valid", b1.rsp_valid, 0);
        check("rw_req_ready", b1.req_ready, 0);
        check("rw_err_count", err_count1, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check("rw_rel_ready_low", b1.req_ready, 0);
        tick();
        check("rw_rel_ready_high", b1.req_ready, 1);
        check("rw_rel_busy", busy1, 0);

        // err_count saturation
        for (int i = 0; i < 300; i++) begin
            do_req(1'b0, 16'h0200 + 16'(i), 16'h0, rd, er, lat);
        end
        check("sat_err_count", err_count1, 255);
        do_req(1'b0, 16'h0005, 16'h0, rd, er, lat);
        check("sat_ld5_rdata", rd, 16'hBEEF);
        check("sat_ld5_err", er, 0);
        check("sat_ld5_lat", lat, 2);
        check("sat_err_hold", err_count1, 255);
        check("sat_we_cycles", we_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
